// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
// Processor stores to DATA are queued in a small byte FIFO. A bit-serial engine
// drains the FIFO onto tx. STATUS reports full/empty/busy/overflow and the
// FIFO occupancy. Loads are returned one cycle later through a registered port.
module mmio_uart_tx #(
    parameter int unsigned INPUT_CLOCK_RATE = 33_333_333,
    parameter int unsigned BAUD_RATE        = 19_200,
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter logic [31:0] BASE_ADDRESS     = 32'h0000_7f40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] io_memory_write,
    output logic [31:0] io_memory_read,
    output logic        valid_io_read,
    output logic        tx
);

    localparam int unsigned CLKS_PER_BIT   = INPUT_CLOCK_RATE / BAUD_RATE;
    localparam int unsigned CNT_W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W          = PTR_W + 1;
    localparam logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd4;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic data_sel;
    logic status_sel;
    logic push_req;
    logic status_wr;
    logic unused_store_bits;

    assign data_sel          = (address == BASE_ADDRESS);
    assign status_sel        = (address == STATUS_ADDRESS);
    assign push_req          = MemWrite && data_sel;
    assign status_wr         = MemWrite && status_sel;
    // Upper store bits carry no meaning for either register.
    assign unused_store_bits = ^io_memory_write[31:8];

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop;
    logic             overflow;

    assign fifo_full  = (fifo_count == OCC_FULL);
    assign fifo_empty = (fifo_count == '0);
    // A push into a full FIFO still fits when the engine pops in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO storage write port.
    // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid, and an unreset array can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= io_memory_write[7:0];
        end
    end

    // FIFO pointers and occupancy.
    // NOTE: sequential state is assigned with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + OCC_W'(1);
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - OCC_W'(1);
            end
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by software.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (status_wr && io_memory_write[3]) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit engine
    // ------------------------------------------------------------------
    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             baud_done;
    logic             busy;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    // Next-state, pop request and next serial level.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_next    = state;
        baud_cnt_next = baud_cnt + CNT_W'(1);
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        pop           = 1'b0;
        tx_next       = 1'b1;

        case (state)
            ST_IDLE: begin
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered, so tx is a pure flop output.
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    // Transmit engine registers, including the registered serial output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {19'd0, 5'(fifo_count), 4'd0, overflow, busy, fifo_empty, fifo_full};

    // Registered load response: one-cycle valid pulse, data zero unless STATUS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_io_read  <= 1'b0;
            io_memory_read <= '0;
        end else begin
            valid_io_read  <= MemRead && (data_sel || status_sel);
            io_memory_read <= (MemRead && status_sel) ? status_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx.
// The reference model tracks the FIFO as a queue and the transmitter as a
// countdown over the 10-bit frame; expected tx, load data and valid come from it.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h0000_7f40;
    localparam logic [31:0] STAT  = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] io_memory_write = '0;
    logic [31:0] io_memory_read;
    logic        valid_io_read;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    int          m_timer;   // cycles left in the current frame, 0 when idle
    logic [7:0]  m_cur;
    logic        m_ovf;
    logic        m_valid;
    logic [31:0] m_rdata;

    mmio_uart_tx #(
        .INPUT_CLOCK_RATE(16),
        .BAUD_RATE(4),
        .FIFO_DEPTH(DEPTH),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .io_memory_write(io_memory_write),
        .io_memory_read(io_memory_read),
        .valid_io_read(valid_io_read),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_timer = 0;
        m_cur   = '0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_rdata = '0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (m_q.size() == DEPTH);
        s[1]    = (m_q.size() == 0);
        s[2]    = (m_timer > 0) || (m_q.size() > 0);
        s[3]    = m_ovf;
        s[12:8] = 5'(m_q.size());
        return s;
    endfunction

    // Expected line level: frame is start(0), 8 data bits LSB first, stop(1).
    function automatic logic exp_tx();
        int slot;
        if (m_timer == 0) return 1'b1;
        slot = (FRAME - m_timer) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    // One bus cycle: drive, advance the model at the edge, return at the next falling edge.
    task automatic tick(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] st;
        int          size_pre;
        logic        do_pop;
        MemWrite        = we;
        MemRead         = re;
        address         = addr;
        io_memory_write = wd;
        @(posedge clk);
        st       = m_status();
        size_pre = m_q.size();
        m_valid  = re && (addr == BASE || addr == STAT);
        m_rdata  = (re && addr == STAT) ? st : 32'h0;
        do_pop   = (size_pre > 0) && (m_timer <= 1);
        if (do_pop) begin
            m_cur   = m_q.pop_front();
            m_timer = FRAME;
        end else if (m_timer > 0) begin
            m_timer--;
        end
        if (we && addr == BASE) begin
            if (size_pre == DEPTH && !do_pop) m_ovf = 1'b1;
            else m_q.push_back(wd[7:0]);
        end
        if (we && addr == STAT && wd[3]) m_ovf = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (valid_io_read !== 1'b0 || io_memory_read !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd: valid=%b data=%h want 0/0", valid_io_read, io_memory_read); end
        rst = 1'b1;
        tick(1'b0, 1'b1, STAT, 32'h0);
        n_checks++; if (valid_io_read !== 1'b1 || io_memory_read !== 32'h2) begin
            n_fail++; $display("FAIL reset_status: valid=%b data=%h want 1/00000002", valid_io_read, io_memory_read); end
        tick(1'b0, 1'b0, STAT, 32'h0);
        n_checks++; if (valid_io_read !== 1'b0 || io_memory_read !== 32'h0) begin
            n_fail++; $display("FAIL valid_pulse: valid=%b data=%h want 0/0", valid_io_read, io_memory_read); end
        tick(1'b0, 1'b1, BASE, 32'h0);
        n_checks++; if (valid_io_read !== 1'b1 || io_memory_read !== 32'h0) begin
            n_fail++; $display("FAIL data_load: valid=%b data=%h want 1/0", valid_io_read, io_memory_read); end
        tick(1'b0, 1'b1, BASE + 32'd8, 32'h0);
        n_checks++; if (valid_io_read !== 1'b0 || io_memory_read !== 32'h0) begin
            n_fail++; $display("FAIL nomatch_load: valid=%b data=%h want 0/0", valid_io_read, io_memory_read); end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b want 1", tx); end
    endtask

    task automatic test_single_frame();
        logic [9:0] frame_bits;
        logic       want;
        frame_bits = {1'b1, 8'h55, 1'b0};
        tick(1'b1, 1'b0, BASE, 32'hFFFF_FF55);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL start_latency: tx=%b want 1", tx); end
        for (int i = 1; i <= 42; i++) begin
            tick(1'b0, (i >= 41), STAT, 32'h0);
            want = (i <= FRAME) ? frame_bits[(i - 1) / CPB] : 1'b1;
            n_checks++; if (tx !== want) begin n_fail++; $display("FAIL frame55 cyc %0d: tx=%b want %b", i, tx, want); end
        end
        // The load sampled at the final stop edge still sees busy; the next one does not.
        n_checks++; if (io_memory_read !== 32'h2 || valid_io_read !== 1'b1) begin
            n_fail++; $display("FAIL busy_clear: data=%h valid=%b want 00000002/1", io_memory_read, valid_io_read); end
    endtask

    task automatic test_overflow();
        for (int b = 0; b < 10; b++) begin
            tick(1'b1, 1'b0, BASE, {$urandom_range(0, 255), 16'h0, 8'(b)} );
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL burst_tx %0d: tx=%b want %b", b, tx, exp_tx()); end
        end
        tick(1'b1, 1'b0, STAT, 32'hFFFF_FFF7);   // bit3 clear: must not touch overflow
        tick(1'b0, 1'b1, STAT, 32'h0);
        n_checks++; if (io_memory_read !== 32'h0000_080D || io_memory_read !== m_rdata) begin
            n_fail++; $display("FAIL overflow_status: got %h want 0000080d", io_memory_read); end
    endtask

    task automatic test_clear_overflow();
        tick(1'b1, 1'b0, STAT, 32'h8);
        tick(1'b0, 1'b1, STAT, 32'h0);
        n_checks++; if (io_memory_read !== 32'h0000_0805 || io_memory_read !== m_rdata) begin
            n_fail++; $display("FAIL clear_overflow: got %h want 00000805", io_memory_read); end
        for (int i = 0; i < 10 * FRAME && (m_q.size() > 0 || m_timer > 0); i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL drain1 cyc %0d: tx=%b want %b", i, tx, exp_tx()); end
        end
    endtask

    task automatic test_full_pop();
        for (int b = 0; b < 9; b++) begin
            tick(1'b1, 1'b0, BASE, 32'(8'hA0 + b));
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL fill_tx %0d: tx=%b want %b", b, tx, exp_tx()); end
        end
        for (int i = 0; i < FRAME && m_timer != 1; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL wait_tx %0d: tx=%b want %b", i, tx, exp_tx()); end
        end
        tick(1'b1, 1'b0, BASE, 32'h0000_00C3);   // coincides with the stop-to-start pop
        tick(1'b0, 1'b1, STAT, 32'h0);
        n_checks++; if (io_memory_read !== 32'h0000_0805 || io_memory_read !== m_rdata) begin
            n_fail++; $display("FAIL full_pop_status: got %h want 00000805", io_memory_read); end
        for (int i = 0; i < 10 * FRAME && (m_q.size() > 0 || m_timer > 0); i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL drain2 cyc %0d: tx=%b want %b", i, tx, exp_tx()); end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, BASE, 32'h0000_0000);
        // Run into data bit 3 (slot 4 of the frame), second cycle of that bit.
        for (int i = 0; i < FRAME && m_timer != FRAME - (4 * CPB + 1); i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL pre_reset cyc %0d: tx=%b want %b", i, tx, exp_tx()); end
        end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", tx); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 1'b1, STAT, 32'h0);
        n_checks++; if (io_memory_read !== 32'h2 || valid_io_read !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_status: data=%h valid=%b want 00000002/1", io_memory_read, valid_io_read); end
        for (int i = 0; i < FRAME + 5; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx cyc %0d: tx=%b want 1", i, tx); end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        int          sel;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       addr = BASE;
                1:       addr = STAT;
                2:       addr = BASE + 32'd8;
                default: addr = $urandom();
            endcase
            // Heavy store traffic early forces overflow, lighter traffic later drains.
            we = (i < 600) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) == 0);
            wd = $urandom();
            tick(we, re, addr, wd);
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL rand_tx cyc %0d: tx=%b want %b", i, tx, exp_tx()); end
            n_checks++; if (valid_io_read !== m_valid || io_memory_read !== m_rdata) begin
                n_fail++; $display("FAIL rand_load cyc %0d: valid=%b data=%h want %b/%h", i, valid_io_read, io_memory_read, m_valid, m_rdata); end
        end
        for (int i = 0; i < 10 * FRAME && (m_q.size() > 0 || m_timer > 0); i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (tx !== exp_tx()) begin n_fail++; $display("FAIL rand_drain cyc %0d: tx=%b want %b", i, tx, exp_tx()); end
        end
        tick(1'b0, 1'b1, STAT, 32'h0);
        n_checks++; if (io_memory_read !== m_rdata || io_memory_read[2:0] !== 3'b010) begin
            n_fail++; $display("FAIL rand_final_status: got %h want %h", io_memory_read, m_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_clear_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
